// File: rtl/fft_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pingpong_ctrl
//  Description : Ping-pong buffer scheduler for the FFT input path.
//                Writes whole frames of N = 2**LOG2N samples into one half of
//                an external dual-port RAM while the other half is streamed
//                out to the FFT core, optionally in bit-reversed order.
//                Owns every RAM strobe and the per-bank full bookkeeping.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1           clock for this block and both RAM ports
//    rst        in   1           synchronous active-high reset
//    s_data     in   DATA_WIDTH  input sample
//    s_valid    in   1           input sample valid
//    s_ready    out  1           a sample can be accepted this cycle
//    ram_waddr  out  LOG2N+1     RAM write address {wr_bank, wr_cnt}
//    ram_din    out  DATA_WIDTH  RAM write data (s_data passed through)
//    ram_wen    out  1           RAM write enable
//    ram_raddr  out  LOG2N+1     RAM read address {rd_bank, rd index}
//    ram_ren    out  1           RAM read enable
//    ram_dout   in   DATA_WIDTH  RAM registered read data (holds when ren=0)
//    m_data     out  DATA_WIDTH  output sample (ram_dout passed through)
//    m_valid    out  1           output sample valid
//    m_ready    in   1           downstream accepts the sample
//    m_last     out  1           marks the final sample of a frame
//    bank_full  out  2           per-bank full flags
// ============================================================================
module fft_pingpong_ctrl #(
   parameter int LOG2N      = 10,
   parameter int DATA_WIDTH = 32,
   parameter int BITREV     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   // streaming sample input
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   // RAM write port
   output logic [LOG2N:0]        ram_waddr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_wen,
   // RAM read port
   output logic [LOG2N:0]        ram_raddr,
   output logic                  ram_ren,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   // streaming sample output
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   // status
   output logic [1:0]            bank_full
);

   // Index of the final sample in a frame (N-1 is all ones).
   localparam logic [LOG2N-1:0] c_last_idx = '1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic             r_wr_bank;
   logic [LOG2N-1:0] r_wr_cnt;
   logic             r_rd_bank;
   logic [LOG2N-1:0] r_rd_cnt;
   logic [1:0]       r_bank_full;
   state_t           r_state;
   logic             r_m_valid;
   logic             r_m_last;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic             w_s_ready;
   logic             w_wen;
   logic             w_wr_last;
   logic             w_slot_free;
   logic             w_issue;
   logic             w_rd_last;
   state_t           w_state_nxt;
   logic [LOG2N-1:0] w_rd_idx;
   logic [1:0]       w_set_mask;
   logic [1:0]       w_clr_mask;

   // ------------------------------------------------------------------------
   // Write side: accept while the bank under the write pointer is not full.
   // ------------------------------------------------------------------------
   assign w_s_ready = ~r_bank_full[r_wr_bank];
   assign w_wen     = s_valid & w_s_ready;
   assign w_wr_last = (r_wr_cnt == c_last_idx);

   assign s_ready   = w_s_ready;
   assign ram_wen   = w_wen;
   assign ram_waddr = {r_wr_bank, r_wr_cnt};
   assign ram_din   = s_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
      end else if (w_wen) begin
         // Counter wraps naturally from N-1 back to 0.
         r_wr_cnt <= r_wr_cnt + 1'b1;
         if (w_wr_last) begin
            r_wr_bank <= ~r_wr_bank;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read address: natural or bit-reversed index within the read bank.
   // ------------------------------------------------------------------------
   generate
      if (BITREV != 0) begin : g_rev_on
         for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign w_rd_idx[gi] = r_rd_cnt[LOG2N-1-gi];
         end
      end else begin : g_rev_off
         assign w_rd_idx = r_rd_cnt;
      end
   endgenerate

   assign ram_raddr = {r_rd_bank, w_rd_idx};

   // ------------------------------------------------------------------------
   // Read FSM
   // The output slot is free when it is empty or being drained this cycle.
   // A read is only issued into a free slot, so with the slot occupied the
   // RAM read port idles and ram_dout keeps presenting the pending sample.
   // ------------------------------------------------------------------------
   assign w_slot_free = ~r_m_valid | m_ready;
   assign w_rd_last   = (r_rd_cnt == c_last_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_issue     = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (r_bank_full[r_rd_bank] && w_slot_free) begin
               w_issue     = 1'b1;
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (w_slot_free) begin
               w_issue = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Frame boundary: continue straight into the other bank when it is
      // already full, so consecutive frames stream without a bubble.
      if (w_issue && w_rd_last) begin
         w_state_nxt = r_bank_full[~r_rd_bank] ? ST_READ : ST_IDLE;
      end
   end

   assign ram_ren = w_issue;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_bank <= 1'b0;
         r_rd_cnt  <= '0;
      end else if (w_issue) begin
         r_rd_cnt <= r_rd_cnt + 1'b1;
         if (w_rd_last) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output valid/last track the issued reads. Since the RAM output is
   // registered, these flags line up with ram_dout one cycle after issue.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (w_issue) begin
         r_m_valid <= 1'b1;
         r_m_last  <= w_rd_last;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end
   end

   assign m_data  = ram_dout;
   assign m_valid = r_m_valid;
   assign m_last  = r_m_last;

   // ------------------------------------------------------------------------
   // Bank bookkeeping. A set needs the write bank to be not full and a clear
   // needs the read bank to be full, so a same-cycle set and clear always
   // target different banks and both apply.
   // ------------------------------------------------------------------------
   assign w_set_mask = (w_wen && w_wr_last)   ? {r_wr_bank, ~r_wr_bank} : 2'b00;
   assign w_clr_mask = (w_issue && w_rd_last) ? {r_rd_bank, ~r_rd_bank} : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bank_full <= 2'b00;
      end else begin
         r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
      end
   end

   assign bank_full = r_bank_full;

endmodule
`default_nettype wire

// File: tb/tb_fft_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_pingpong_ctrl
//  Description : Directed self-checking bench for fft_pingpong_ctrl with
//                N = 8. A bit-reversing instance is the main target; a
//                natural-order instance shares the same stimulus. Each
//                instance has a behavioural RAM with registered read data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_pingpong_ctrl;

   localparam int LOG2N = 3;
   localparam int DW    = 16;
   localparam int N     = 8;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            c;
   } xfer_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          m_ready = 1'b1;

   // bit-reversing instance
   logic          s_ready, ram_wen, ram_ren, m_valid, m_last;
   logic [LOG2N:0] ram_waddr, ram_raddr;
   logic [DW-1:0] ram_din, ram_dout, m_data;
   logic [1:0]    bank_full;
   // natural-order instance
   logic          s_ready2, ram_wen2, ram_ren2, m_valid2, m_last2;
   logic [LOG2N:0] ram_waddr2, ram_raddr2;
   logic [DW-1:0] ram_din2, ram_dout2, m_data2;
   logic [1:0]    bank_full2;

   logic [DW-1:0] mem1 [0:2*N-1];
   logic [DW-1:0] mem2 [0:2*N-1];

   int n_checks = 0;
   int n_errors = 0;

   // stimulus / monitor state
   logic [DW-1:0] in_q[$];
   xfer_t         out_q[$];
   xfer_t         out2_q[$];
   logic [LOG2N:0] raddr_q[$];
   logic [LOG2N:0] raddr2_q[$];
   logic [LOG2N:0] waddr_q[$];
   int  cyc = 0;
   int  acc_cnt = 0;
   int  last_acc_cyc = 0;
   int  first_rise = -1;
   int  stall_cnt = 0;
   bit  ready_val = 1'b1;
   bit  ready_mode = 1'b0;
   bit  prev_hold = 1'b0;
   bit  prev_valid = 1'b0;
   logic [DW-1:0] prev_data = '0;

   int rev_tbl[N] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft_pingpong_ctrl #(.LOG2N(LOG2N), .DATA_WIDTH(DW), .BITREV(1)) u_dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_wen(ram_wen),
      .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_dout(ram_dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .bank_full(bank_full)
   );

   fft_pingpong_ctrl #(.LOG2N(LOG2N), .DATA_WIDTH(DW), .BITREV(0)) u_dut_nat (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
      .ram_waddr(ram_waddr2), .ram_din(ram_din2), .ram_wen(ram_wen2),
      .ram_raddr(ram_raddr2), .ram_ren(ram_ren2), .ram_dout(ram_dout2),
      .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2),
      .bank_full(bank_full2)
   );

   always #5 clk = ~clk;

   // behavioural RAMs: registered read, output holds while ren=0
   always @(posedge clk) begin
      if (ram_wen)  mem1[ram_waddr]  <= ram_din;
      if (ram_ren)  ram_dout         <= mem1[ram_raddr];
      if (ram_wen2) mem2[ram_waddr2] <= ram_din2;
      if (ram_ren2) ram_dout2        <= mem2[ram_raddr2];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Feeder: presents the head of in_q, pops it once accepted; drives m_ready.
   always begin
      bit acc;
      @(negedge clk);
      acc = s_valid && s_ready && !rst;
      if (acc) begin
         acc_cnt++;
         last_acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc && in_q.size() > 0) void'(in_q.pop_front());
      if (in_q.size() > 0) begin
         s_valid = 1'b1;
         s_data  = in_q[0];
      end else begin
         s_valid = 1'b0;
      end
      m_ready = ready_mode ? ($urandom_range(0, 1) == 1) : ready_val;
   end

   // Monitor: transfers, addresses, hold stability, stalls.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", m_valid, 1'b1);
            check("hold_data", m_data, prev_data);
         end
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
         if (m_valid && !prev_valid && first_rise < 0) first_rise = cyc;
         prev_valid = m_valid;
         if (m_valid && m_ready)  out_q.push_back('{d: m_data, l: m_last, c: cyc});
         if (m_valid2 && m_ready) out2_q.push_back('{d: m_data2, l: m_last2, c: cyc});
         if (ram_ren)  raddr_q.push_back(ram_raddr);
         if (ram_ren2) raddr2_q.push_back(ram_raddr2);
         if (ram_wen)  waddr_q.push_back(ram_waddr);
         if (s_valid && !s_ready) stall_cnt++;
      end
   end

   task automatic clear_tb();
      out_q.delete(); out2_q.delete();
      raddr_q.delete(); raddr2_q.delete(); waddr_q.delete();
      acc_cnt = 0; first_rise = -1; stall_cnt = 0;
   endtask

   task automatic reset_dut(input int edges);
      @(posedge clk); #2;
      rst = 1'b1;
      in_q.delete();
      repeat (edges) @(posedge clk);
      #2;
      rst = 1'b0;
      clear_tb();
   endtask

   task automatic push_range(input int first, input int count);
      for (int i = 0; i < count; i++) in_q.push_back(DW'(first + i));
   endtask

   task automatic wait_acc(input int n, input int budget, input string tag);
      int i = 0;
      while (acc_cnt < n && i < budget) begin
         @(posedge clk); #2;
         i++;
      end
      check(tag, acc_cnt, n);
   endtask

   task automatic wait_out(input int n, input int budget, input string tag);
      int i = 0;
      while (out_q.size() < n && i < budget) begin
         @(posedge clk); #2;
         i++;
      end
      check(tag, out_q.size(), n);
   endtask

   // Expected frame f, position k: base + 8f + (bit-reversed k).
   task automatic check_frames(input int base, input int nfr, input string tag);
      for (int i = 0; i < nfr * N; i++) begin
         if (i >= out_q.size()) break;
         check({tag, "_data"}, out_q[i].d, base + (i / N) * N + rev_tbl[i % N]);
         check({tag, "_last"}, out_q[i].l, ((i % N) == N - 1));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      // ---------------- reset state ----------------
      reset_dut(3);
      @(negedge clk);
      check("rst_s_ready", s_ready, 1'b1);
      check("rst_s_ready_nat", s_ready2, 1'b1);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_last", m_last, 1'b0);
      check("rst_bank_full", bank_full, 2'b00);
      check("rst_wen", ram_wen, 1'b0);
      check("rst_ren", ram_ren, 1'b0);

      // ---------------- single frame ----------------
      push_range(0, N);
      wait_acc(N, 50, "t1_acc");
      wait_out(N, 50, "t1_out");
      check("t1_latency", first_rise - last_acc_cyc, 2);
      check_frames(0, 1, "t1");
      for (int k = 0; k < N; k++) begin
         if (k < raddr_q.size())  check("t1_raddr", raddr_q[k], rev_tbl[k]);
         if (k < raddr2_q.size()) check("t1_raddr_nat", raddr2_q[k], k);
         if (k < out2_q.size()) begin
            check("t1_nat_data", out2_q[k].d, k);
            check("t1_nat_last", out2_q[k].l, (k == N - 1));
         end
      end
      check("t1_nat_count", out2_q.size(), N);
      repeat (3) @(negedge clk);
      check("t1_bank_full", bank_full, 2'b00);
      check("t1_bank_full_nat", bank_full2, 2'b00);
      check("t1_wr_bank_nat", ram_waddr2[LOG2N], 1'b1);
      check("t1_rd_bank_nat", ram_raddr2[LOG2N], 1'b1);

      // ---------------- continuous 4 frames ----------------
      reset_dut(1);
      push_range(0, 4 * N);
      wait_out(4 * N, 120, "t2_out");
      check("t2_stalls", stall_cnt, 0);
      check_frames(0, 4, "t2");
      if (out_q.size() == 4 * N) check("t2_no_bubble", out_q[4*N-1].c - out_q[N].c, 3 * N - 1);

      // ---------------- backpressure ----------------
      reset_dut(1);
      ready_val = 1'b0;
      push_range(0, 3 * N);
      wait_acc(2 * N, 60, "t3_acc16");
      @(negedge clk);
      check("t3_bank_full", bank_full, 2'b11);
      check("t3_s_ready", s_ready, 1'b0);
      check("t3_m_valid", m_valid, 1'b1);
      check("t3_ren", ram_ren, 1'b0);
      check("t3_pending", m_data, 0);
      repeat (5) @(negedge clk);
      check("t3_no_write", acc_cnt, 2 * N);
      check("t3_pending_hold", m_data, 0);
      ready_val = 1'b1;
      wait_out(3 * N, 120, "t3_out");
      check_frames(0, 3, "t3");
      repeat (3) @(negedge clk);
      check("t3_s_ready_back", s_ready, 1'b1);
      check("t3_bank_empty", bank_full, 2'b00);

      // ---------------- random m_ready ----------------
      reset_dut(1);
      ready_mode = 1'b1;
      push_range(100, 3 * N);
      wait_out(3 * N, 400, "t4_out");
      ready_mode = 1'b0;
      check_frames(100, 3, "t4");

      // ---------------- reset mid-stream ----------------
      reset_dut(1);
      ready_val = 1'b1;
      push_range(0, 2 * N);
      wait_acc(N + 5, 60, "t5_acc");
      check("t5_reading", m_valid, 1'b1);
      rst = 1'b1;
      in_q.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      clear_tb();
      @(negedge clk);
      check("t5_m_valid", m_valid, 1'b0);
      check("t5_bank_full", bank_full, 2'b00);
      check("t5_s_ready", s_ready, 1'b1);
      push_range(0, N);
      wait_out(N, 60, "t5_out");
      for (int k = 0; k < N; k++) begin
         if (k < waddr_q.size()) check("t5_waddr", waddr_q[k], k);
      end
      check_frames(0, 1, "t5");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fft_pingpong_ctrl.md
Name: fft_pingpong_ctrl

Overview:
- Ping-pong buffer scheduler for the FFT input path.
- Accepts a streaming sample input and writes whole frames of N = 2^LOG2N samples into one half of an external dual-port RAM (DPRAM_WRAP, instantiated with ADDR_WIDTH = LOG2N+1, wclk = rclk = clk).
- While it writes one half, it reads the other half out to the FFT core, optionally in bit-reversed address order.
- Owns all RAM control (addresses, wen, ren) and the bank full/empty bookkeeping.

Parameters:
- LOG2N, 10: log2 of frame length N; RAM address width is LOG2N+1.
- DATA_WIDTH, 32: sample width.
- BITREV, 1: 1 = read addresses bit-reversed within the bank; 0 = natural order.

Ports:
- clk  in  1  single clock for the block and for both RAM ports.
- rst  in  1  synchronous active-high reset.
- s_data  in  DATA_WIDTH  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- ram_waddr  out  LOG2N+1  RAM write address, {wr_bank, wr_cnt}.
- ram_din  out  DATA_WIDTH  RAM write data (equals s_data).
- ram_wen  out  1  RAM write enable.
- ram_raddr  out  LOG2N+1  RAM read address, {rd_bank, rd_cnt or bitrev(rd_cnt)}.
- ram_ren  out  1  RAM read enable.
- ram_dout  in  DATA_WIDTH  RAM registered read data (1-cycle latency, holds when ren=0).
- m_data  out  DATA_WIDTH  output sample (driven directly from ram_dout).
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the sample.
- m_last  out  1  marks sample N-1 of a frame.
- bank_full  out  2  per-bank full flags (status).

Behaviour:
- Reset (sync, rst=1 at a clk edge): wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0, bank_full=2'b00, read FSM=IDLE, m_valid=0, m_last=0, ram_wen=0, ram_ren=0, s_ready=1 after reset. Reset mid-frame discards all partial and full frames; RAM contents are don't-care.
- Write side (combinational strobes):
  - s_ready = !bank_full[wr_bank].
  - ram_wen = s_valid & s_ready.
  - ram_waddr = {wr_bank, wr_cnt}; ram_din = s_data.
- On each accepted write: wr_cnt increments. At wr_cnt = N-1: wr_cnt wraps to 0, bank_full[wr_bank] is set, and wr_bank toggles.
- Both banks full: s_ready=0 and no writes occur; upstream stalls.
- Output slot: slot_free = !m_valid | m_ready.
- Read FSM, two states:
  - IDLE: if bank_full[rd_bank] & slot_free, issue a read of rd_cnt=0 and go to READ; otherwise stay.
  - READ: issue a read whenever slot_free. No read is issued while the slot is not free, so ram_dout holds the pending sample.
- Issuing a read means:
  - ram_ren=1 (combinational); ram_raddr = {rd_bank, BITREV ? bitrev(rd_cnt) : rd_cnt}.
  - m_valid<=1; m_last <= (rd_cnt==N-1); rd_cnt increments.
- Last issue of a frame (rd_cnt = N-1):
  - rd_cnt wraps to 0, bank_full[rd_bank] clears, rd_bank toggles.
  - Next state is READ if the other bank is already full (back-to-back frames with no bubble), else IDLE.
- No issue and m_ready=1: m_valid<=0 and m_last<=0.
- Transfer occurs on m_valid & m_ready. m_data, m_valid and m_last are aligned because ram_dout is registered.
- Set and clear of bank_full in the same cycle always hit different banks (a set requires !full), so both take effect.
- Latency: if the final sample of a frame is accepted at edge T and the read side is idle, the first read issues at edge T+1 and m_valid is high after T+1. Steady state with m_ready=1 gives one sample per clock.
- Throughput: continuous input at one sample per clock with m_ready=1 never deasserts s_ready.
- Width rules: counters are LOG2N bits and wrap naturally. bitrev reverses bit order of the LOG2N-bit index.

Test Plan:
- Reset, single frame (LOG2N=3, BITREV=1): write samples 0..7 back-to-back, m_ready=1. Required: m_data order 0,4,2,6,1,5,3,7; m_last only on the 8th; m_valid high 2 cycles after the last s_valid&s_ready; bank_full returns to 00.
- BITREV=0, same stimulus: output order 0..7; ram_raddr 0..7; wr_bank and rd_bank both end at 1.
- Continuous stream of 4 frames (values 0..31) with m_ready=1: s_ready never drops; m_valid has no bubble between frames 2, 3 and 4; every frame is reordered correctly.
- Backpressure: hold m_ready=0 while writing 3 frames. Required: bank_full=11 after 16 samples and s_ready=0 from the 17th. The first pending sample is held stable on m_data with m_valid=1 (ram_ren=0). On m_ready=1 the frame drains, then s_ready returns to 1.
- Random m_ready (50%) with 3 frames: scoreboard sees no loss or duplication, m_last every 8th transfer, and m_data is stable while m_valid & !m_ready.
- Reset asserted after 5 samples of frame 2, while frame 1 is being read. Required: the next cycle shows m_valid=0, bank_full=00, s_ready=1; a fresh frame 0..7 is then written at address 0..7 and output correctly.
